// File: rtl/gpr_pkg.sv
// Shared definitions for GPR initiators: op codes, FSM states, default widths, address field slots.
// Define GPR_ACCUM_EN to enable the ACCUM op and its write-back (WB) state.
package gpr_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 12;
  localparam int REG_W_DEF  = 4;

  localparam logic [1:0] OP_READ_SUM = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_ACCUM    = 2'b10;

  // Field slots in the packed read address, in units of REG_W (srca lands in the MSBs).
  localparam int SLOT_A = 2;
  localparam int SLOT_B = 1;
  localparam int SLOT_C = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_CAP   = 3'd2,
`ifdef GPR_ACCUM_EN
    ST_WB       = 3'd3,
`endif
    ST_WR_ISSUE = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/gpr_addr_pack.sv
// Packs three source indices, or a zero-extended destination index, into a GPR address.
// Expects ADDR_W >= 3*REG_W.
module gpr_addr_pack
  import gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              i_sel_dst,
  input  logic [REG_W-1:0]  i_srca,
  input  logic [REG_W-1:0]  i_srcb,
  input  logic [REG_W-1:0]  i_srcc,
  input  logic [REG_W-1:0]  i_dst,
  output logic [ADDR_W-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    if (i_sel_dst) begin
      o_addr[REG_W-1:0] = i_dst;
    end else begin
      o_addr[SLOT_A*REG_W +: REG_W] = i_srca;
      o_addr[SLOT_B*REG_W +: REG_W] = i_srcb;
      o_addr[SLOT_C*REG_W +: REG_W] = i_srcc;
    end
  end

endmodule

// File: rtl/gpr_access_ctrl.sv
// GPR initiator: sequences read/write strobes for operand requests and returns the sum or write echo.
// Define GPR_ACCUM_EN to enable ACCUM write-back; otherwise ACCUM behaves as READ_SUM.
module gpr_access_ctrl
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [REG_W-1:0]  req_srca,
  input  logic [REG_W-1:0]  req_srcb,
  input  logic [REG_W-1:0]  req_srcc,
  input  logic [REG_W-1:0]  req_dst,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] gpr_address,
  output logic [DATA_W-1:0] gpr_data_in,
  input  logic [DATA_W-1:0] gpr_data_out,
  output logic              gpr_rd,
  output logic              gpr_wr
);

  state_t              r_state, w_state_nxt;
  logic                r_gpr_rd, r_gpr_wr;
  logic [ADDR_W-1:0]   r_gpr_address;
  logic [DATA_W-1:0]   r_gpr_data_in, r_rsp_data;

  logic                w_rd_nxt, w_wr_nxt;
  logic [ADDR_W-1:0]   w_packed, w_addr_nxt;
  logic [DATA_W-1:0]   w_din_nxt;
  logic [REG_W-1:0]    w_dst;

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);

`ifdef GPR_ACCUM_EN
  logic             r_accum;
  logic [REG_W-1:0] r_dst;

  // Only the write-back needs request fields after the issue cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accum <= 1'b0;
      r_dst   <= '0;
    end else if (req_valid && req_ready) begin
      r_accum <= (req_op == OP_ACCUM);
      r_dst   <= req_dst;
    end
  end

  assign w_dst = (r_state == ST_IDLE) ? req_dst : r_dst;
`else
  assign w_dst = req_dst;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (req_valid)
                     w_state_nxt = (req_op == OP_WRITE) ? ST_WR_ISSUE : ST_RD_ISSUE;
      ST_RD_ISSUE: w_state_nxt = ST_RD_CAP;
`ifdef GPR_ACCUM_EN
      ST_RD_CAP:   w_state_nxt = r_accum ? ST_WB : ST_RESP;
      ST_WB:       w_state_nxt = ST_RESP;
`else
      ST_RD_CAP:   w_state_nxt = ST_RESP;
`endif
      ST_WR_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:     if (rsp_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so they line up exactly with the issuing state.
  always_comb begin
    w_rd_nxt  = (w_state_nxt == ST_RD_ISSUE);
    w_wr_nxt  = (w_state_nxt == ST_WR_ISSUE);
    w_din_nxt = '0;
    if (w_state_nxt == ST_WR_ISSUE) w_din_nxt = req_data;
`ifdef GPR_ACCUM_EN
    if (w_state_nxt == ST_WB) begin
      w_wr_nxt  = 1'b1;
      w_din_nxt = gpr_data_out;
    end
`endif
    w_addr_nxt = (w_rd_nxt || w_wr_nxt) ? w_packed : '0;
  end

  gpr_addr_pack #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_pack (
    .i_sel_dst (w_wr_nxt),
    .i_srca    (req_srca),
    .i_srcb    (req_srcb),
    .i_srcc    (req_srcc),
    .i_dst     (w_dst),
    .o_addr    (w_packed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_gpr_rd      <= 1'b0;
      r_gpr_wr      <= 1'b0;
      r_gpr_address <= '0;
      r_gpr_data_in <= '0;
      r_rsp_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_gpr_rd      <= w_rd_nxt;
      r_gpr_wr      <= w_wr_nxt;
      r_gpr_address <= w_addr_nxt;
      r_gpr_data_in <= w_din_nxt;
      if (r_state == ST_RD_CAP)
        r_rsp_data <= gpr_data_out;
      else if (r_state == ST_WR_ISSUE)
        r_rsp_data <= r_gpr_data_in;
    end
  end

  assign gpr_rd      = r_gpr_rd;
  assign gpr_wr      = r_gpr_wr;
  assign gpr_address = r_gpr_address;
  assign gpr_data_in = r_gpr_data_in;
  assign rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Bench for gpr_access_ctrl: GPR behavioural model, directed table, corner sequences, random vs reference model.
module tb_gpr_access_ctrl;

`ifdef GPR_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = '0;
  logic [3:0]  req_srca = '0, req_srcb = '0, req_srcc = '0, req_dst = '0;
  logic [13:0] req_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [13:0] rsp_data;
  logic [11:0] gpr_address;
  logic [13:0] gpr_data_in;
  logic [13:0] gpr_data_out = '0;
  logic        gpr_rd, gpr_wr;

  gpr_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_srcc(req_srcc),
    .req_dst(req_dst), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .gpr_address(gpr_address), .gpr_data_in(gpr_data_in),
    .gpr_data_out(gpr_data_out), .gpr_rd(gpr_rd), .gpr_wr(gpr_wr)
  );

  always #5 clk = ~clk;

  // GPR model: registered three-operand sum on read, write on wr.
  logic [13:0] gpr_mem [16];
  initial for (int i = 0; i < 16; i++) gpr_mem[i] = '0;
  always @(posedge clk) begin
    if (gpr_wr) gpr_mem[gpr_address[3:0]] <= gpr_data_in;
    if (gpr_rd) gpr_data_out <= gpr_mem[gpr_address[11:8]] + gpr_mem[gpr_address[7:4]]
                              + gpr_mem[gpr_address[3:0]];
  end

  // Strobe monitor, sampled mid-cycle.
  int          rd_cnt = 0, wr_cnt = 0;
  logic [11:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [13:0] last_wr_data = '0;
  bit          both_seen = 0, idle_bad = 0;
  always @(negedge clk) begin
    if (gpr_rd && gpr_wr) both_seen = 1;
    if (!gpr_rd && !gpr_wr && gpr_address != '0) idle_bad = 1;
    if (!gpr_wr && gpr_data_in != '0) idle_bad = 1;
    if (gpr_rd) begin rd_cnt++; last_rd_addr = gpr_address; end
    if (gpr_wr) begin wr_cnt++; last_wr_addr = gpr_address; last_wr_data = gpr_data_in; end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: architectural register file updated from the op rules.
  logic [13:0] ref_mem [16];
  task automatic model(input logic [1:0] op, input logic [3:0] a, b, c, d,
                       input logic [13:0] data, output logic [13:0] exp, output int lat);
    logic [13:0] s;
    s = ref_mem[a] + ref_mem[b] + ref_mem[c];
    if (op == 2'b01) begin ref_mem[d] = data; exp = data; lat = 1; end
    else if (op == 2'b10 && ACC) begin ref_mem[d] = s; exp = s; lat = 3; end
    else begin exp = s; lat = 2; end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] a, b, c, d,
                        input logic [13:0] data, input int stall,
                        output logic [13:0] rsp, output int lat, output int rd_d, output int wr_d);
    int rd0, wr0;
    logic [31:0] r;
    rd0 = rd_cnt; wr0 = wr_cnt; rsp = '0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_srca = a; req_srcb = b; req_srcc = c;
    req_dst = d; req_data = data; rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    r = $urandom;
    req_op = r[1:0]; req_srca = r[5:2]; req_srcb = r[9:6]; req_srcc = r[13:10];
    req_dst = r[17:14]; req_data = r[31:18];
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      rd_d = rd_cnt - rd0; wr_d = wr_cnt - wr0;
      return;
    end
    rsp = rsp_data;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, rsp);
      chk("hold_not_ready", req_ready, 0);
    end
    @(negedge clk); rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("idle_after_hs", req_ready, 1);
    rd_d = rd_cnt - rd0; wr_d = wr_cnt - wr0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  a, b, c, d;
    logic [13:0] data;
    logic [13:0] exp;
    int          lat;
    logic [11:0] addr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [13:0] rsp, mexp;
    int lat, mlat, rd_d, wr_d, ewr;
    logic [31:0] r;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    tbl[0] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd1, 14'h1000, 14'h1000, 1, 12'h001};
    tbl[1] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd2, 14'h2000, 14'h2000, 1, 12'h002};
    tbl[2] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd3, 14'h1500, 14'h1500, 1, 12'h003};
    tbl[3] = '{2'b00, 4'd1, 4'd2, 4'd3, 4'd0, 14'h0000, 14'h0500, 2, 12'h123};
    tbl[4] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd5, 14'h3FFF, 14'h3FFF, 1, 12'h005};
    tbl[5] = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd1, 14'h0003, 14'h0003, 1, 12'h001};
    tbl[6] = '{2'b10, 4'd1, 4'd1, 4'd1, 4'd4, 14'h0000, 14'h0009, ACC ? 3 : 2, 12'h111};
    tbl[7] = '{2'b00, 4'd4, 4'd0, 4'd0, 4'd0, 14'h0000, ACC ? 14'h0009 : 14'h0000, 2, 12'h400};
    tbl[8] = '{2'b11, 4'd1, 4'd2, 4'd3, 4'd7, 14'h0000, 14'h3503, 2, 12'h123};
    tbl[9] = '{2'b00, 4'd5, 4'd5, 4'd5, 4'd0, 14'h0000, 14'h3FFD, 2, 12'h555};

    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_strobes", {gpr_rd, gpr_wr}, 0);
    chk("rst_addr", gpr_address, 0);
    chk("rst_din", gpr_data_in, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].data, mexp, mlat);
      do_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].data, i % 3, rsp, lat, rd_d, wr_d);
      ewr = (tbl[i].op == 2'b01 || (ACC && tbl[i].op == 2'b10)) ? 1 : 0;
      chk($sformatf("tbl%0d_rsp", i), rsp, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_rd_pulses", i), rd_d, (tbl[i].op == 2'b01) ? 0 : 1);
      chk($sformatf("tbl%0d_wr_pulses", i), wr_d, ewr);
      if (tbl[i].op == 2'b01) chk($sformatf("tbl%0d_wr_addr", i), last_wr_addr, tbl[i].addr);
      else                    chk($sformatf("tbl%0d_rd_addr", i), last_rd_addr, tbl[i].addr);
      if (ewr == 1) begin
        chk($sformatf("tbl%0d_wr_data", i), last_wr_data, tbl[i].exp);
        chk($sformatf("tbl%0d_wr_dst", i), last_wr_addr, {8'h00, tbl[i].d});
      end
    end

    // Long response stall: output held, no extra strobes.
    model(2'b00, 4'd1, 4'd2, 4'd3, 4'd0, 14'h0, mexp, mlat);
    do_req(2'b00, 4'd1, 4'd2, 4'd3, 4'd0, 14'h0, 10, rsp, lat, rd_d, wr_d);
    chk("stall_rsp", rsp, 14'h3503);
    chk("stall_rd_pulses", rd_d, 1);
    chk("stall_wr_pulses", wr_d, 0);

    // Reset while the read strobe is up.
    @(negedge clk);
    req_valid = 1; req_op = 2'b00; req_srca = 4'd1; req_srcb = 4'd2; req_srcc = 4'd3;
    @(posedge clk); #1;
    req_valid = 0;
    chk("mid_rd_high", gpr_rd, 1);
    rst_n = 0; #1;
    chk("mid_rst_rd_drop", gpr_rd, 0);
    chk("mid_rst_addr", gpr_address, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(negedge clk); rst_n = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("mid_rst_no_rsp", rsp_valid, 0);
      chk("mid_rst_idle", req_ready, 1);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 1000; n++) begin
      r = $urandom;
      model(r[1:0], r[5:2], r[9:6], r[13:10], r[17:14], r[31:18], mexp, mlat);
      do_req(r[1:0], r[5:2], r[9:6], r[13:10], r[17:14], r[31:18], n % 3, rsp, lat, rd_d, wr_d);
      chk($sformatf("rnd%0d_rsp", n), rsp, mexp);
      chk($sformatf("rnd%0d_lat", n), lat, mlat);
      if (r[1:0] == 2'b01) chk($sformatf("rnd%0d_wr_addr", n), last_wr_addr, {8'h00, r[17:14]});
      else chk($sformatf("rnd%0d_rd_addr", n), last_rd_addr, {r[5:2], r[9:6], r[13:10]});
    end

    chk("never_rd_and_wr", both_seen, 0);
    chk("addr_din_zero_when_idle", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_access_ctrl.md
# gpr_access_ctrl

Initiator-side controller for the GPR register file. It accepts operand requests over a valid/ready interface and sequences the GPR read and write strobes, packed address and write data. It captures the registered three-operand sum and returns it over a valid/ready response channel. It sits between the CPU control unit and the GPR block and owns all GPR strobe timing.

## Interface
- DATA_W, 14, GPR word width
- ADDR_W, 12, GPR address width
- REG_W, 4, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  00 READ_SUM, 01 WRITE, 10 ACCUM, 11 reserved
- req_srca, req_srcb, req_srcc  in  REG_W each  source indices
- req_dst  in  REG_W  destination index
- req_data  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  sum, or echoed write data
- gpr_address  out  ADDR_W  to GPR address
- gpr_data_in  out  DATA_W  to GPR write data
- gpr_data_out  in  DATA_W  from GPR registered read data
- gpr_rd, gpr_wr  out  1 each  GPR strobes, never high together

## Operation
- FSM states: IDLE, RD_ISSUE, RD_CAP, WB, WR_ISSUE, RESP.
- Requests are accepted when req_valid && req_ready. req_ready = (state == IDLE), combinational.
- All request fields are latched on acceptance. Input changes after acceptance have no effect.
- READ_SUM:
  - IDLE → RD_ISSUE.
  - RD_ISSUE: gpr_rd=1; gpr_address = {srca, srcb, srcc}, srca in the MSBs ([11:8], [7:4], [3:0]).
  - RD_CAP: gpr_rd=0; gpr_data_out is registered into rsp_data at the end of the cycle.
  - RD_CAP → RESP.
- WRITE:
  - IDLE → WR_ISSUE.
  - WR_ISSUE: gpr_wr=1; gpr_address = zero-extended dst, so bit 4 is 0; gpr_data_in = data; rsp_data <= data.
  - WR_ISSUE → RESP.
- ACCUM: same as READ_SUM through RD_CAP, then WB, then RESP.
  - WB: gpr_wr=1, gpr_address = zero-extended dst, gpr_data_in = captured sum.
- RESP: rsp_valid=1, held with rsp_data stable until rsp_ready. On handshake → IDLE.
- Reserved op 11 executes as READ_SUM.
- Arithmetic: the sum is modulo 2^DATA_W (wrap is produced by the GPR); the controller does no arithmetic.
- Strobes, gpr_address and gpr_data_in are registered outputs. They are 0 in every state other than the issuing one.

## Timing
- Reset values (async, immediate):
  - state IDLE, req_ready=1.
  - rsp_valid=0, rsp_data=0.
  - gpr_rd=0, gpr_wr=0, gpr_address=0, gpr_data_in=0.
- Accept at edge k:
  - READ_SUM: gpr_rd high k→k+1; rsp_valid high from k+2.
  - WRITE: gpr_wr high k→k+1; rsp_valid high from k+1.
  - ACCUM: gpr_wr high k+2→k+3; rsp_valid high from k+3.
- After the RESP handshake at edge m, the next request is accepted no earlier than edge m+1.
- Sustained READ_SUM throughput with rsp_ready tied high: one request per 4 cycles.
- rsp_ready held low: stay in RESP indefinitely, with no GPR strobes.
- Reset mid-operation: the operation is aborted and strobes drop asynchronously. No response is issued. A write already strobed at an edge may have completed.

## Configuration
- GPR_ACCUM_EN defined: ACCUM op behaves as specified, with the WB state present.
- GPR_ACCUM_EN undefined: WB state is absent and ACCUM (10) executes as READ_SUM with no write-back.

## Structure
- gpr_pkg:
  - op encodings: OP_READ_SUM, OP_WRITE, OP_ACCUM.
  - FSM state enum.
  - default widths.
  - field offset constants for the packed address.
- Sub-module gpr_addr_pack: combinational packing of three indices, or a zero-extended dst, into ADDR_W bits. Shared with any future GPR initiator.

## Test plan
- Write R1=0x1000, R2=0x2000, R3=0x1500, then READ_SUM(1,2,3) → gpr_address=0x123, rsp_data=0x0500 (wrap mod 0x4000), rsp_valid 2 cycles after accept.
- WRITE dst=5 data=0x3FFF → one-cycle gpr_wr, gpr_address=0x005, rsp_data=0x3FFF one cycle after accept.
- ACCUM(1,1,1 → dst 4) with R1=0x0003, GPR_ACCUM_EN defined → gpr_wr with data 0x0009 to address 0x004; a later READ_SUM(4,0,0) with R0=0 returns 0x0009. With GPR_ACCUM_EN undefined → no gpr_wr, rsp_data=0x0009.
- rsp_ready held low for 10 cycles → rsp_valid and rsp_data stable, req_ready=0, no strobes. Release → IDLE next edge.
- Assert rst_n=0 during RD_ISSUE → gpr_rd=0 immediately, no rsp_valid after release, req_ready=1.
- Random ops for 1000 requests → gpr_rd && gpr_wr never both high; results match a scoreboard model.
